// File: rtl/cache_ctrl_pkg.sv
// Shared types and tree-PLRU helpers for the set-associative cache controller.
// Helpers work on a 7-bit node vector (enough for 8 ways); unused upper nodes stay 0.
package cache_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COMPARE,
        S_WRITEBACK,
        S_ALLOCATE
    } cache_ctrl_state_t;

    localparam int PLRU_MAX_BITS = 7;
    typedef logic [PLRU_MAX_BITS-1:0] plru_bits_t;

    // Nodes are heap-ordered (children of n are 2n+1, 2n+2); a node bit of 1 points right.
    function automatic plru_bits_t plru_update(input plru_bits_t bits, input int unsigned way,
                                               input int unsigned num_ways);
        plru_bits_t  r_res;
        int unsigned node;
        logic        dir;
        r_res = bits;
        node  = 0;
        for (int lvl = 0; lvl < 3; lvl++) begin
            if ((32'd1 << lvl) < num_ways) begin
                dir              = ((way & (num_ways >> (lvl + 1))) != 0);
                r_res[node[2:0]] = ~dir;
                node             = 2 * node + 1 + 32'(dir);
            end
        end
        return r_res;
    endfunction

    function automatic int unsigned plru_victim(input plru_bits_t bits, input int unsigned num_ways);
        int unsigned node;
        node = 0;
        for (int lvl = 0; lvl < 3; lvl++) begin
            if ((32'd1 << lvl) < num_ways) begin
                node = 2 * node + 1 + 32'(bits[node[2:0]]);
            end
        end
        return node - (num_ways - 1);
    endfunction

endpackage

// File: rtl/cache_ctrl_plru.sv
// Per-set tree-PLRU state: NUM_SETS x (NUM_WAYS-1) node bits, victim read and hit update.
module plru_tree
    import cache_ctrl_pkg::*;
#(
    parameter  int NUM_WAYS = 4,
    parameter  int NUM_SETS = 8,
    localparam int WAY_W    = $clog2(NUM_WAYS),
    localparam int SET_W    = $clog2(NUM_SETS)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [SET_W-1:0] i_set,
    input  logic             i_upd_en,
    input  logic [WAY_W-1:0] i_upd_way,
    output logic [WAY_W-1:0] o_victim
);

    logic [NUM_WAYS-2:0] r_bits [NUM_SETS];
    plru_bits_t          w_cur;
    plru_bits_t          w_next;

    assign w_cur    = plru_bits_t'(r_bits[i_set]);
    assign w_next   = plru_update(w_cur, 32'(i_upd_way), NUM_WAYS);
    assign o_victim = WAY_W'(plru_victim(w_cur, NUM_WAYS));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                r_bits[s] <= '0;
            end
        end else if (i_upd_en) begin
            r_bits[i_set] <= w_next[NUM_WAYS-2:0];
        end
    end

endmodule

// File: rtl/cache_ctrl.sv
// N-way set-associative write-back cache controller FSM with tree-PLRU replacement.
// Optional performance counters (hit/miss/writeback) when CACHE_CTRL_PERF_EN is defined.
module cache_ctrl
    import cache_ctrl_pkg::*;
#(
    parameter  int NUM_WAYS = 4,
    parameter  int NUM_SETS = 8,
    localparam int WAY_W    = $clog2(NUM_WAYS),
    localparam int SET_W    = $clog2(NUM_SETS)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_mem_read,
    input  logic                i_mem_write,
    input  logic [SET_W-1:0]    i_set_idx,
    input  logic [NUM_WAYS-1:0] i_way_hit,
    input  logic [NUM_WAYS-1:0] i_way_valid,
    input  logic [NUM_WAYS-1:0] i_way_dirty,
    input  logic                i_pmem_resp,
    output logic                o_mem_resp,
    output logic                o_pmem_read,
    output logic                o_pmem_write,
    output logic [NUM_WAYS-1:0] o_load_way,
    output logic                o_fill_sel,
    output logic                o_addr_sel,
    output logic [WAY_W-1:0]    o_victim_way,
    output logic                o_set_dirty,
`ifdef CACHE_CTRL_PERF_EN
    output logic [31:0]         o_hit_cnt,
    output logic [31:0]         o_miss_cnt,
    output logic [31:0]         o_wb_cnt,
`endif
    output logic                o_clr_dirty
);

    cache_ctrl_state_t   r_state;
    cache_ctrl_state_t   w_next_state;
    logic [WAY_W-1:0]    r_victim_way;
    logic [WAY_W-1:0]    w_plru_victim;
    logic [WAY_W-1:0]    w_hit_idx;
    logic [WAY_W-1:0]    w_inv_idx;
    logic [WAY_W-1:0]    w_victim_sel;
    logic [NUM_WAYS-1:0] w_hit_oh;
    logic                w_req;
    logic                w_hit;
    logic                w_plru_upd;

    assign w_req        = i_mem_read | i_mem_write;
    assign w_hit        = |i_way_hit;
    // A multi-hot way_hit is illegal; fall back to the lowest matching way.
    assign w_hit_oh     = i_way_hit & (~i_way_hit + NUM_WAYS'(1));
    assign w_victim_sel = (&i_way_valid) ? w_plru_victim : w_inv_idx;
    assign w_plru_upd   = !i_rst && (r_state == S_COMPARE) && w_req && w_hit;
    assign o_victim_way = r_victim_way;

    always_comb begin
        w_hit_idx = '0;
        w_inv_idx = '0;
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (i_way_hit[i])    w_hit_idx = WAY_W'(i);
            if (!i_way_valid[i]) w_inv_idx = WAY_W'(i);
        end
    end

    plru_tree #(.NUM_WAYS(NUM_WAYS), .NUM_SETS(NUM_SETS)) u_plru (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_set     (i_set_idx),
        .i_upd_en  (w_plru_upd),
        .i_upd_way (w_hit_idx),
        .o_victim  (w_plru_victim)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_victim_way <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == S_COMPARE && w_req && !w_hit) begin
                r_victim_way <= w_victim_sel;
            end
        end
    end

    // Outputs are forced low while rst is high so an aborted miss never writes the arrays.
    always_comb begin
        w_next_state = r_state;
        o_mem_resp   = 1'b0;
        o_pmem_read  = 1'b0;
        o_pmem_write = 1'b0;
        o_load_way   = '0;
        o_fill_sel   = 1'b0;
        o_addr_sel   = 1'b0;
        o_set_dirty  = 1'b0;
        o_clr_dirty  = 1'b0;
        if (!i_rst) begin
            case (r_state)
                S_IDLE: begin
                    if (w_req) w_next_state = S_COMPARE;
                end
                S_COMPARE: begin
                    if (!w_req) begin
                        w_next_state = S_IDLE;
                    end else if (w_hit) begin
                        o_mem_resp   = 1'b1;
                        w_next_state = S_IDLE;
                        if (i_mem_write) begin
                            o_load_way  = w_hit_oh;
                            o_set_dirty = 1'b1;
                        end
                    end else begin
                        w_next_state = i_way_dirty[w_victim_sel] ? S_WRITEBACK : S_ALLOCATE;
                    end
                end
                S_WRITEBACK: begin
                    o_pmem_write = 1'b1;
                    o_addr_sel   = 1'b1;
                    if (i_pmem_resp) w_next_state = S_ALLOCATE;
                end
                S_ALLOCATE: begin
                    o_pmem_read = 1'b1;
                    if (i_pmem_resp) begin
                        o_load_way   = NUM_WAYS'(1) << r_victim_way;
                        o_fill_sel   = 1'b1;
                        o_clr_dirty  = 1'b1;
                        w_next_state = S_COMPARE;
                    end
                end
                default: w_next_state = S_IDLE;
            endcase
        end
    end

    always @(posedge i_clk) begin
        if (!i_rst && r_state == S_COMPARE) begin
            assert ($onehot0(i_way_hit));
        end
    end

`ifdef CACHE_CTRL_PERF_EN
    logic w_cnt_hit;
    logic w_cnt_miss;
    logic w_cnt_wb;

    assign w_cnt_hit  = (r_state == S_COMPARE) && w_req && w_hit;
    assign w_cnt_miss = (r_state == S_COMPARE) && w_req && !w_hit;
    assign w_cnt_wb   = (r_state == S_WRITEBACK) && i_pmem_resp;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_hit_cnt  <= '0;
            o_miss_cnt <= '0;
            o_wb_cnt   <= '0;
        end else begin
            if (w_cnt_hit && !(&o_hit_cnt))   o_hit_cnt  <= o_hit_cnt + 32'd1;
            if (w_cnt_miss && !(&o_miss_cnt)) o_miss_cnt <= o_miss_cnt + 32'd1;
            if (w_cnt_wb && !(&o_wb_cnt))     o_wb_cnt   <= o_wb_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl (4 ways, 8 sets) with a response/fill scoreboard
// and a small physical-memory responder.
module tb_cache_ctrl;

    typedef struct packed {
        logic [3:0] load_way;
        logic       set_dirty;
        logic       fill_sel;
    } resp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       mem_read, mem_write;
    logic [2:0] set_idx;
    logic [3:0] way_hit, way_valid, way_dirty;
    logic       pmem_resp;
    logic       mem_resp, pmem_read, pmem_write, fill_sel, addr_sel, set_dirty, clr_dirty;
    logic [3:0] load_way;
    logic [1:0] victim_way;
`ifdef CACHE_CTRL_PERF_EN
    logic [31:0] hit_cnt, miss_cnt, wb_cnt;
`endif

    resp_t      resp_q[$];
    logic [3:0] fill_q[$];
    logic [3:0] hit_after;
    int         n_total = 0;
    int         n_pass  = 0;
    int         n_fail  = 0;
    int         fill_cnt = 0;
    int         wb_seen  = 0;
    int         busy     = 0;

    cache_ctrl #(.NUM_WAYS(4), .NUM_SETS(8)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_mem_read   (mem_read),
        .i_mem_write  (mem_write),
        .i_set_idx    (set_idx),
        .i_way_hit    (way_hit),
        .i_way_valid  (way_valid),
        .i_way_dirty  (way_dirty),
        .i_pmem_resp  (pmem_resp),
        .o_mem_resp   (mem_resp),
        .o_pmem_read  (pmem_read),
        .o_pmem_write (pmem_write),
        .o_load_way   (load_way),
        .o_fill_sel   (fill_sel),
        .o_addr_sel   (addr_sel),
        .o_victim_way (victim_way),
        .o_set_dirty  (set_dirty),
`ifdef CACHE_CTRL_PERF_EN
        .o_hit_cnt    (hit_cnt),
        .o_miss_cnt   (miss_cnt),
        .o_wb_cnt     (wb_cnt),
`endif
        .o_clr_dirty  (clr_dirty)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Physical memory: answers any read/write after three busy cycles.
    always begin
        @(negedge clk);
        #2;
        if (pmem_resp) begin
            pmem_resp = 1'b0;
            busy      = 0;
        end else if (rst || !(pmem_read || pmem_write)) begin
            busy = 0;
        end else begin
            busy++;
            if (busy == 3) begin
                pmem_resp = 1'b1;
                busy      = 0;
                #1;
                if (pmem_read) begin
                    chk("fill_expected", 32'(fill_q.size() != 0), 32'd1);
                    if (fill_q.size() != 0) begin
                        chk("fill_load_way", 32'(load_way), 32'(fill_q.pop_front()));
                        chk("fill_sel", 32'(fill_sel), 32'd1);
                        chk("fill_clr_dirty", 32'(clr_dirty), 32'd1);
                        chk("fill_addr_sel", 32'(addr_sel), 32'd0);
                    end
                    fill_cnt++;
                end else begin
                    chk("wb_addr_sel", 32'(addr_sel), 32'd1);
                    chk("wb_load_way", 32'(load_way), 32'd0);
                    wb_seen++;
                end
            end
        end
    end

    task automatic issue(input logic wr, input logic [2:0] set, input logic [3:0] hit,
                         input logic [3:0] valid, input logic [3:0] dirty, input logic [3:0] haf);
        @(negedge clk);
        #1;
        mem_read  = ~wr;
        mem_write = wr;
        set_idx   = set;
        way_hit   = hit;
        way_valid = valid;
        way_dirty = dirty;
        hit_after = haf;
    endtask

    task automatic wait_resp(input string tag, input int exp_n);
        int    n   = 0;
        int    f0  = fill_cnt;
        bit    got = 1'b0;
        resp_t e;
        while (!got && n < 40) begin
            @(negedge clk);
            #1;
            n++;
            if (fill_cnt != f0) way_hit = hit_after;
            #3;
            if (mem_resp) got = 1'b1;
        end
        chk({tag, "_latency"}, 32'(n), 32'(exp_n));
        if (got) begin
            chk({tag, "_resp_expected"}, 32'(resp_q.size() != 0), 32'd1);
            e = (resp_q.size() != 0) ? resp_q.pop_front() : '0;
            chk({tag, "_load_way"}, 32'(load_way), 32'(e.load_way));
            chk({tag, "_set_dirty"}, 32'(set_dirty), 32'(e.set_dirty));
            chk({tag, "_fill_sel"}, 32'(fill_sel), 32'(e.fill_sel));
        end
        @(negedge clk);
        #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        way_hit   = 4'b0000;
        #3;
        chk({tag, "_single_pulse"}, 32'(mem_resp), 32'd0);
    endtask

    task automatic read_hit(input logic [2:0] set, input logic [3:0] hit);
        resp_q.push_back('{load_way: 4'b0000, set_dirty: 1'b0, fill_sel: 1'b0});
        issue(1'b0, set, hit, 4'b1111, 4'b0000, hit);
        wait_resp("plru_hit", 1);
    endtask

    initial begin
        int wb0, f0;
        rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; set_idx = '0;
        way_hit = '0; way_valid = '0; way_dirty = '0; pmem_resp = 1'b0; hit_after = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_mem_resp", 32'(mem_resp), 32'd0);
        chk("rst_pmem", 32'({pmem_read, pmem_write}), 32'd0);
        chk("rst_load_way", 32'(load_way), 32'd0);
        chk("rst_victim", 32'(victim_way), 32'd0);
        rst = 1'b0;

        // Read hit, set 3 way 1
        resp_q.push_back('{load_way: 4'b0000, set_dirty: 1'b0, fill_sel: 1'b0});
        issue(1'b0, 3'd3, 4'b0010, 4'b1111, 4'b0000, 4'b0010);
        #3;
        chk("rd_hit_req_cycle", 32'(mem_resp), 32'd0);
        wait_resp("rd_hit", 1);

        // Write hit, way 2
        resp_q.push_back('{load_way: 4'b0100, set_dirty: 1'b1, fill_sel: 1'b0});
        issue(1'b1, 3'd1, 4'b0100, 4'b1111, 4'b0000, 4'b0100);
        wait_resp("wr_hit", 1);

        // Clean read miss, first invalid way is 2
        wb0 = wb_seen; f0 = fill_cnt;
        fill_q.push_back(4'b0100);
        resp_q.push_back('{load_way: 4'b0000, set_dirty: 1'b0, fill_sel: 1'b0});
        issue(1'b0, 3'd2, 4'b0000, 4'b1011, 4'b0000, 4'b0100);
        wait_resp("clean_miss", 5);
        chk("clean_miss_victim", 32'(victim_way), 32'd2);
        chk("clean_miss_no_wb", 32'(wb_seen - wb0), 32'd0);
        chk("clean_miss_fills", 32'(fill_cnt - f0), 32'd1);

        // Dirty write miss on set 3: PLRU after the way-1 hit picks way 2
        wb0 = wb_seen; f0 = fill_cnt;
        fill_q.push_back(4'b0100);
        resp_q.push_back('{load_way: 4'b0100, set_dirty: 1'b1, fill_sel: 1'b0});
        issue(1'b1, 3'd3, 4'b0000, 4'b1111, 4'b0100, 4'b0100);
        wait_resp("dirty_miss", 9);
        chk("dirty_miss_victim", 32'(victim_way), 32'd2);
        chk("dirty_miss_wb", 32'(wb_seen - wb0), 32'd1);
        chk("dirty_miss_fills", 32'(fill_cnt - f0), 32'd1);

        // PLRU walk on set 5
        read_hit(3'd5, 4'b0001);
        read_hit(3'd5, 4'b0010);
        read_hit(3'd5, 4'b0100);
        read_hit(3'd5, 4'b1000);
        fill_q.push_back(4'b0001);
        resp_q.push_back('{load_way: 4'b0000, set_dirty: 1'b0, fill_sel: 1'b0});
        issue(1'b0, 3'd5, 4'b0000, 4'b1111, 4'b0000, 4'b0001);
        wait_resp("plru_miss0", 5);
        chk("plru_victim0", 32'(victim_way), 32'd0);
        read_hit(3'd5, 4'b0100);
        read_hit(3'd5, 4'b0001);
        read_hit(3'd5, 4'b0010);
        fill_q.push_back(4'b1000);
        resp_q.push_back('{load_way: 4'b0000, set_dirty: 1'b0, fill_sel: 1'b0});
        issue(1'b0, 3'd5, 4'b0000, 4'b1111, 4'b0000, 4'b1000);
        wait_resp("plru_miss3", 5);
        chk("plru_victim3", 32'(victim_way), 32'd3);

        // Reset during ALLOCATE aborts the miss
        f0 = fill_cnt;
        issue(1'b0, 3'd0, 4'b0000, 4'b0111, 4'b0000, 4'b1000);
        repeat (2) @(negedge clk);
        #1;
        chk("abort_in_alloc", 32'(pmem_read), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("abort_pmem_read", 32'(pmem_read), 32'd0);
        chk("abort_load_way", 32'(load_way), 32'd0);
        chk("abort_mem_resp", 32'(mem_resp), 32'd0);
        chk("abort_victim", 32'(victim_way), 32'd0);
        mem_read = 1'b0;
        rst      = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        chk("abort_no_fill", 32'(fill_cnt - f0), 32'd0);
        chk("abort_idle_pmem", 32'({pmem_read, pmem_write}), 32'd0);
`ifdef CACHE_CTRL_PERF_EN
        chk("abort_miss_cnt", miss_cnt, 32'd0);
        chk("abort_hit_cnt", hit_cnt, 32'd0);
`endif

        // PLRU cleared by reset: after a way-3 hit the victim is way 0
        read_hit(3'd5, 4'b1000);
        fill_q.push_back(4'b0001);
        resp_q.push_back('{load_way: 4'b0000, set_dirty: 1'b0, fill_sel: 1'b0});
        issue(1'b0, 3'd5, 4'b0000, 4'b1111, 4'b0000, 4'b0001);
        wait_resp("post_rst_miss", 5);
        chk("post_rst_victim", 32'(victim_way), 32'd0);
`ifdef CACHE_CTRL_PERF_EN
        chk("perf_hit_cnt", hit_cnt, 32'd2);
        chk("perf_miss_cnt", miss_cnt, 32'd1);
        chk("perf_wb_cnt", wb_cnt, 32'd0);
`endif

        chk("resp_q_drained", 32'(resp_q.size()), 32'd0);
        chk("fill_q_drained", 32'(fill_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "timeout");
    end

endmodule
